// File: rtl/mc_alu_if.sv
// mc_alu_if: request/response bundle between the multicycle controller and mc_alu.
//
// Signals
//   start      controller -> ALU  request, honoured only while busy is low
//   ALUControl controller -> ALU  4-bit opcode, captured with start
//   SrcA/SrcB  controller -> ALU  WIDTH-bit operands, captured with start
//   busy       ALU -> controller  an operation is in flight
//   done       ALU -> controller  one-cycle pulse when Result/Result2/ALUFlags update
//   Result     ALU -> controller  primary result (low product / quotient)
//   Result2    ALU -> controller  secondary result (high product / remainder)
//   ALUFlags   ALU -> controller  {N, Z, C, V}
//
// Modports: master is the controller side, slave is the ALU side.
interface mc_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result2;
    logic [3:0]       ALUFlags;

    modport master (
        output start, ALUControl, SrcA, SrcB,
        input  busy, done, Result, Result2, ALUFlags
    );

    modport slave (
        input  start, ALUControl, SrcA, SrcB,
        output busy, done, Result, Result2, ALUFlags
    );
endinterface

// File: rtl/mc_alu.sv
// mc_alu: multicycle ALU.
// ADD/SUB/AND/OR/MOV and unknown opcodes finish in one cycle.
// MUL/UMULL/SMULL use an iterative shift-add multiplier.
// UDIV/SDIV use an iterative restoring divider.
// Both iterative units work on operand magnitudes in a 2*WIDTH register.
// Signed results are fixed up in the FINISH state.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mc_alu_if.slave carrying:
//            start, ALUControl, SrcA, SrcB  (in)
//            busy, done, Result, Result2, ALUFlags  (out)
module mc_alu #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    mc_alu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_MOV   = 4'b0101;
    localparam logic [3:0] OP_UMULL = 4'b0110;
    localparam logic [3:0] OP_SMULL = 4'b0111;
    localparam logic [3:0] OP_UDIV  = 4'b1000;
    localparam logic [3:0] OP_SDIV  = 4'b1001;

    typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   origA_q, origB_q;
    logic [WIDTH-1:0]   operand_q;
    logic               negA_q, negB_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   result_q, result2_q;
    logic [3:0]         flags_q;
    logic               done_q;

    function automatic logic isIterOp(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL) ||
               (op == OP_UDIV) || (op == OP_SDIV);
    endfunction

    // Operand magnitudes for the iterative units.
    // Only SMULL/SDIV treat their inputs as signed.
    logic             signedIn, divIn;
    logic [WIDTH-1:0] magA, magB;
    always_comb begin
        signedIn = (bus.ALUControl == OP_SMULL) || (bus.ALUControl == OP_SDIV);
        divIn    = (bus.ALUControl == OP_UDIV) || (bus.ALUControl == OP_SDIV);
        magA     = (signedIn && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
        magB     = (signedIn && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
    end

    // Single-cycle datapath.
    // SUB is A + ~B + 1, so the carry out means "no borrow".
    logic             isSub;
    logic [WIDTH-1:0] bOperand;
    logic [WIDTH:0]   sumExt;
    logic [WIDTH-1:0] scResult;
    logic             scCarry, scOverflow;
    always_comb begin
        isSub      = (bus.ALUControl == OP_SUB);
        bOperand   = isSub ? ~bus.SrcB : bus.SrcB;
        sumExt     = {1'b0, bus.SrcA} + {1'b0, bOperand} + (WIDTH+1)'(isSub);
        scResult   = '0;
        scCarry    = 1'b0;
        scOverflow = 1'b0;
        case (bus.ALUControl)
            OP_ADD, OP_SUB: begin
                scResult   = sumExt[WIDTH-1:0];
                scCarry    = sumExt[WIDTH];
                scOverflow = (bus.SrcA[WIDTH-1] == bOperand[WIDTH-1]) &&
                             (sumExt[WIDTH-1] != bus.SrcA[WIDTH-1]);
            end
            OP_AND:  scResult = bus.SrcA & bus.SrcB;
            OP_OR:   scResult = bus.SrcA | bus.SrcB;
            OP_MOV:  scResult = bus.SrcB;
            default: scResult = '0;
        endcase
    end

    // One iteration step.
    // Multiply: acc = {partial, multiplier}; add the multiplicand into the
    // top half when the LSB is set, then shift right, keeping the carry.
    // Divide: acc = {remainder, dividend}; shift left, trial-subtract the
    // divisor from the top WIDTH+1 bits, keep the difference when no borrow,
    // and shift the quotient bit in at the bottom.
    logic               opIsDiv;
    logic [WIDTH:0]     mulSum, divTrial, divDiff;
    logic [2*WIDTH-1:0] accStep;
    always_comb begin
        opIsDiv  = (op_q == OP_UDIV) || (op_q == OP_SDIV);
        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
        divTrial = acc_q[2*WIDTH-1:WIDTH-1];
        divDiff  = divTrial - {1'b0, operand_q};
        if (opIsDiv) begin
            if (!divDiff[WIDTH])
                accStep = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                accStep = {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            accStep = {mulSum, acc_q[WIDTH-1:1]};
        end
    end

    // Final result selection and sign correction.
    // Divide-by-zero is forced to all-ones / dividend for both divides.
    logic [2*WIDTH-1:0] prodFinal;
    logic [WIDTH-1:0]   quot, rem, finResult, finResult2;
    always_comb begin
        prodFinal = ((op_q == OP_SMULL) && (negA_q ^ negB_q)) ? -acc_q : acc_q;
        quot      = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
        if (op_q == OP_SDIV) begin
            if (negA_q ^ negB_q) quot = -quot;
            if (negA_q)          rem  = -rem;
        end
        finResult  = '0;
        finResult2 = '0;
        case (op_q)
            OP_MUL: finResult = prodFinal[WIDTH-1:0];
            OP_UMULL, OP_SMULL: begin
                finResult  = prodFinal[WIDTH-1:0];
                finResult2 = prodFinal[2*WIDTH-1:WIDTH];
            end
            OP_UDIV, OP_SDIV: begin
                if (origB_q == '0) begin
                    finResult  = '1;
                    finResult2 = origA_q;
                end else begin
                    finResult  = quot;
                    finResult2 = rem;
                end
            end
            default: begin
                finResult  = '0;
                finResult2 = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    // Single-cycle ops never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && isIterOp(bus.ALUControl)) state_d = ITER;
            ITER:    if (cnt_q == LAST_STEP) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered outputs.
    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.done     = done_q;
        bus.Result   = result_q;
        bus.Result2  = result2_q;
        bus.ALUFlags = flags_q;
    end

    // Datapath registers.
    // Results are written either straight from IDLE (single-cycle ops)
    // or from FINISH (iterative ops); otherwise they hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= '0;
            origA_q   <= '0;
            origB_q   <= '0;
            operand_q <= '0;
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
            result2_q <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (isIterOp(bus.ALUControl)) begin
                            op_q      <= bus.ALUControl;
                            origA_q   <= bus.SrcA;
                            origB_q   <= bus.SrcB;
                            negA_q    <= signedIn && bus.SrcA[WIDTH-1];
                            negB_q    <= signedIn && bus.SrcB[WIDTH-1];
                            operand_q <= divIn ? magB : magA;
                            acc_q     <= {{WIDTH{1'b0}}, (divIn ? magA : magB)};
                            cnt_q     <= '0;
                        end else begin
                            result_q  <= scResult;
                            result2_q <= '0;
                            flags_q   <= {scResult[WIDTH-1], (scResult == '0),
                                          scCarry, scOverflow};
                            done_q    <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc_q <= accStep;
                    cnt_q <= cnt_q + CW'(1);
                end
                FINISH: begin
                    result_q  <= finResult;
                    result2_q <= finResult2;
                    flags_q   <= {finResult[WIDTH-1], (finResult == '0), 2'b00};
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
